// File: rtl/stn_bus_sampler.sv
// Oversamples the asynchronous STN LCD bus on clk, emits one framebuffer write per
// lck falling edge with pixel coordinates, and measures the panel geometry.
module stn_bus_sampler #(
    parameter int SYNC_STAGES       = 2,
    parameter int PIX_PER_LCK       = 4,
    parameter int MAX_WIDTH         = 640,
    parameter int MAX_HEIGHT        = 480,
    parameter int LOCK_TIMEOUT_LOG2 = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   lck,
    input  logic                   llp,
    input  logic                   lflm,
    input  logic [PIX_PER_LCK-1:0] ld,
    output logic                   wr_en,
    output logic [9:0]             wr_x,
    output logic [8:0]             wr_y,
    output logic [PIX_PER_LCK-1:0] wr_data,
    output logic                   frame_start,
    output logic [9:0]             frame_width,
    output logic [8:0]             frame_height,
    output logic                   geom_valid,
    output logic                   overrun
);

    localparam logic [9:0] X_LIMIT = 10'(MAX_WIDTH);
    localparam logic [9:0] X_STEP  = 10'(PIX_PER_LCK);
    localparam logic [8:0] Y_LAST  = 9'(MAX_HEIGHT - 1);

    typedef enum logic {
        HUNT,
        ACTIVE
    } state_t;

    logic [SYNC_STAGES-1:0] lck_sync;
    logic [SYNC_STAGES-1:0] llp_sync;
    logic [SYNC_STAGES-1:0] lflm_sync;
    logic                   lck_prev;
    logic                   llp_prev;
    logic [PIX_PER_LCK-1:0] ld_pipe [SYNC_STAGES+1];

    logic                   lck_fall_q;
    logic                   llp_rise_q;
    logic                   first_q;
    logic [PIX_PER_LCK-1:0] ld_aligned;

    state_t                 state;
    logic [9:0]             x;
    logic [8:0]             y;
    logic [9:0]             x_post;
    logic [8:0]             y_post;
    logic                   y_sat;
    logic [9:0]             line_width;
    logic [8:0]             line_count;

    logic                   have_prev;
    logic [9:0]             prev_width;
    logic [8:0]             prev_height;

    logic [LOCK_TIMEOUT_LOG2-1:0] lock_cnt;
    logic                         lock_lost;

    // Events are registered once more so they line up with ld after SYNC_STAGES+1 flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the ld pipeline is small, so it is reset along with the control flops.
            lck_sync   <= '0;
            llp_sync   <= '0;
            lflm_sync  <= '0;
            lck_prev   <= 1'b0;
            llp_prev   <= 1'b0;
            for (int i = 0; i <= SYNC_STAGES; i++) ld_pipe[i] <= '0;
            lck_fall_q <= 1'b0;
            llp_rise_q <= 1'b0;
            first_q    <= 1'b0;
        end else begin
            lck_sync   <= {lck_sync[SYNC_STAGES-2:0], lck};
            llp_sync   <= {llp_sync[SYNC_STAGES-2:0], llp};
            lflm_sync  <= {lflm_sync[SYNC_STAGES-2:0], lflm};
            lck_prev   <= lck_sync[SYNC_STAGES-1];
            llp_prev   <= llp_sync[SYNC_STAGES-1];
            ld_pipe[0] <= ld;
            for (int i = 1; i <= SYNC_STAGES; i++) ld_pipe[i] <= ld_pipe[i-1];
            lck_fall_q <= lck_prev & ~lck_sync[SYNC_STAGES-1];
            llp_rise_q <= ~llp_prev & llp_sync[SYNC_STAGES-1];
            first_q    <= lflm_sync[SYNC_STAGES-1];
        end
    end

    assign ld_aligned = ld_pipe[SYNC_STAGES];

    // Position after any line pulse this cycle; a coincident lck write uses these values.
    always_comb begin
        // NOTE: every always_comb output is defaulted first so no path infers a latch.
        x_post = x;
        y_post = y;
        y_sat  = 1'b0;
        if (llp_rise_q) begin
            x_post = '0;
            if (first_q) begin
                y_post = '0;
            end else if (x != '0) begin
                if (y == Y_LAST) y_sat = 1'b1;
                else             y_post = y + 9'd1;
            end
        end
    end

    assign line_width = (x != '0) ? x : frame_width;
    assign line_count = y + 9'd1;
    assign lock_lost  = (&lock_cnt) & ~llp_rise_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HUNT;
            x            <= '0;
            y            <= '0;
            wr_en        <= 1'b0;
            wr_x         <= '0;
            wr_y         <= '0;
            wr_data      <= '0;
            frame_start  <= 1'b0;
            frame_width  <= '0;
            frame_height <= '0;
            geom_valid   <= 1'b0;
            overrun      <= 1'b0;
            have_prev    <= 1'b0;
            prev_width   <= '0;
            prev_height  <= '0;
            lock_cnt     <= '0;
        end else begin
            // NOTE: non-blocking updates mean every test below sees pre-clock values,
            // and a later assignment to the same register in this block wins.
            wr_en       <= 1'b0;
            frame_start <= 1'b0;

            if (llp_rise_q)       lock_cnt <= '0;
            else if (!(&lock_cnt)) lock_cnt <= lock_cnt + 1'b1;

            if (lock_lost) begin
                state      <= HUNT;
                geom_valid <= 1'b0;
                have_prev  <= 1'b0;
            end else begin
                case (state)
                    HUNT: begin
                        if (llp_rise_q && first_q) begin
                            state       <= ACTIVE;
                            x           <= '0;
                            y           <= '0;
                            frame_start <= 1'b1;
                            overrun     <= 1'b0;
                        end
                    end

                    ACTIVE: begin
                        if (llp_rise_q) begin
                            if (first_q) begin
                                frame_width  <= line_width;
                                frame_height <= line_count;
                                geom_valid   <= have_prev && (line_count == prev_height) &&
                                                (line_width == prev_width);
                                prev_width   <= line_width;
                                prev_height  <= line_count;
                                have_prev    <= 1'b1;
                                frame_start  <= 1'b1;
                                overrun      <= 1'b0;
                            end else begin
                                if (x != '0) frame_width <= x;
                                if (y_sat)   overrun     <= 1'b1;
                            end
                        end
                        x <= x_post;
                        y <= y_post;

                        if (lck_fall_q) begin
                            if (x_post >= X_LIMIT) begin
                                overrun <= 1'b1;
                            end else begin
                                wr_en   <= 1'b1;
                                wr_x    <= x_post;
                                wr_y    <= y_post;
                                wr_data <= ld_aligned;
                                x       <= x_post + X_STEP;
                            end
                        end
                    end

                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stn_bus_sampler.sv
// Scoreboard bench for stn_bus_sampler: a frame-level reference model pushes expected
// writes and frame starts; a monitor pops and compares whenever the DUT strobes.
module tb_stn_bus_sampler;

    localparam int SYNC      = 2;
    localparam int PIX       = 4;
    localparam int MAX_W     = 640;
    localparam int MAX_H     = 480;
    localparam int LOCK_LOG2 = 12;
    localparam int LAT       = SYNC + 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       lck   = 1'b0;
    logic       llp   = 1'b0;
    logic       lflm  = 1'b0;
    logic [3:0] ld    = '0;

    logic       wr_en;
    logic [9:0] wr_x;
    logic [8:0] wr_y;
    logic [3:0] wr_data;
    logic       frame_start;
    logic [9:0] frame_width;
    logic [8:0] frame_height;
    logic       geom_valid;
    logic       overrun;

    stn_bus_sampler #(
        .SYNC_STAGES      (SYNC),
        .PIX_PER_LCK      (PIX),
        .MAX_WIDTH        (MAX_W),
        .MAX_HEIGHT       (MAX_H),
        .LOCK_TIMEOUT_LOG2(LOCK_LOG2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lck         (lck),
        .llp         (llp),
        .lflm        (lflm),
        .ld          (ld),
        .wr_en       (wr_en),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_data     (wr_data),
        .frame_start (frame_start),
        .frame_width (frame_width),
        .frame_height(frame_height),
        .geom_valid  (geom_valid),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int x; int y; int data; int t; } wr_t;
    typedef struct { int w; int h; int gv; } fs_t;
    typedef struct { int w; int h; } geom_t;

    wr_t   wr_q[$];
    fs_t   fs_q[$];
    geom_t frames_q[$];   // geometries measured since lock was last acquired

    bit m_active = 0;
    int mx = 0, my = 0, mw = 0, mh = 0;
    bit mgv = 0, m_ovr = 0;

    task automatic model_reset();
        m_active = 0; mx = 0; my = 0; mw = 0; mh = 0; mgv = 0; m_ovr = 0;
        frames_q.delete();
    endtask

    task automatic model_lost_lock();
        m_active = 0; mgv = 0;
        frames_q.delete();
    endtask

    task automatic model_llp(input bit first);
        geom_t g;
        if (!m_active) begin
            if (first) begin
                m_active = 1; mx = 0; my = 0; m_ovr = 0;
                fs_q.push_back('{mw, mh, int'(mgv)});
            end
        end else if (first) begin
            if (mx != 0) mw = mx;
            mh = my + 1;
            g = '{mw, mh};
            frames_q.push_back(g);
            mgv = (frames_q.size() >= 2) &&
                  (frames_q[$-1].w == frames_q[$].w) && (frames_q[$-1].h == frames_q[$].h);
            mx = 0; my = 0; m_ovr = 0;
            fs_q.push_back('{mw, mh, int'(mgv)});
        end else begin
            if (mx != 0) begin
                mw = mx;
                if (my == MAX_H - 1) m_ovr = 1;
                else                 my = my + 1;
            end
            mx = 0;
        end
    endtask

    task automatic model_lck(input int data);
        if (!m_active) return;
        if (mx >= MAX_W) begin
            m_ovr = 1;
            return;
        end
        wr_q.push_back('{mx, my, data, cyc});
        mx = mx + PIX;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        wr_t e;
        fs_t f;
        if (rst_n) begin
            if (wr_en) begin
                if (wr_q.size() == 0) check("unexpected_wr_en", 1, 0);
                else begin
                    e = wr_q.pop_front();
                    check("wr_x", int'(wr_x), e.x);
                    check("wr_y", int'(wr_y), e.y);
                    check("wr_data", int'(wr_data), e.data);
                    check("wr_latency", cyc - e.t, LAT);
                end
            end
            if (frame_start) begin
                if (fs_q.size() == 0) check("unexpected_frame_start", 1, 0);
                else begin
                    f = fs_q.pop_front();
                    check("fs_width", int'(frame_width), f.w);
                    check("fs_height", int'(frame_height), f.h);
                    check("fs_geom_valid", int'(geom_valid), f.gv);
                end
            end
        end
    end

    // ---------------- stimulus drivers ----------------
    task automatic lck_pulse(input logic [3:0] d);
        @(negedge clk);
        lck = 1'b1;
        ld  = d;
        repeat (2) @(negedge clk);
        lck = 1'b0;
        model_lck(int'(d));
        repeat (2) @(negedge clk);
    endtask

    task automatic llp_pulse(input bit first);
        @(negedge clk);
        llp  = 1'b1;
        lflm = first;
        model_llp(first);
        repeat (2) @(negedge clk);
        llp = 1'b0;
        repeat (2) @(negedge clk);
        lflm = 1'b0;
    endtask

    task automatic lcks(input int n);
        for (int i = 0; i < n; i++) lck_pulse(4'($urandom));
    endtask

    // lck falls and llp rises on the same clk; reports the write that follows.
    task automatic lck_llp_same(input logic [3:0] d, output int sx, output int sy,
                                output int seen);
        @(negedge clk);
        lck = 1'b1;
        ld  = d;
        repeat (2) @(negedge clk);
        lck = 1'b0;
        llp = 1'b1;
        model_llp(1'b0);
        model_lck(int'(d));
        seen = 0; sx = -1; sy = -1;
        for (int k = 0; k < LAT + 4; k++) begin
            @(negedge clk);
            if (wr_en && seen == 0) begin
                seen = 1; sx = int'(wr_x); sy = int'(wr_y);
            end
        end
        llp = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic settle(input string tag);
        repeat (LAT + 6) @(negedge clk);
        check({tag, "_overrun"}, int'(overrun), int'(m_ovr));
        check({tag, "_geom_valid"}, int'(geom_valid), int'(mgv));
        check({tag, "_frame_width"}, int'(frame_width), mw);
        check({tag, "_frame_height"}, int'(frame_height), mh);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int sx, sy, seen;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_wr", int'({wr_en, wr_x, wr_y, wr_data}), 0);
        check("reset_geom", int'({frame_start, frame_width, frame_height, geom_valid, overrun}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // HUNT: lck and a plain line pulse are ignored
        lcks(5);
        llp_pulse(1'b0);
        lcks(3);
        settle("hunt");

        // One line of 160 nibbles of 4'hA
        llp_pulse(1'b1);
        for (int i = 0; i < 160; i++) lck_pulse(4'hA);
        settle("line160");

        // Two full frames, 160 lck per line, 6 lines each
        for (int f = 0; f < 2; f++) begin
            llp_pulse(1'b1);
            for (int l = 0; l < 6; l++) begin
                if (l != 0) llp_pulse(1'b0);
                lcks(160);
            end
        end
        llp_pulse(1'b1);
        settle("frames");
        check("frames_width_640", int'(frame_width), 640);
        check("frames_height_6", int'(frame_height), 6);
        check("frames_geom_valid", int'(geom_valid), 1);

        // 170 lck on one line: x saturates, overrun sets, then clears at frame start
        lcks(170);
        settle("xsat");
        check("xsat_overrun_set", int'(overrun), 1);
        llp_pulse(1'b1);
        settle("xsat_clear");
        check("xsat_overrun_clear", int'(overrun), 0);

        // y saturation: more lines than MAX_HEIGHT
        for (int i = 0; i < MAX_H + 1; i++) begin
            lck_pulse(4'($urandom));
            llp_pulse(1'b0);
        end
        lcks(2);
        settle("ysat");
        check("ysat_overrun_set", int'(overrun), 1);
        llp_pulse(1'b1);
        settle("ysat_frame");
        check("ysat_height_480", int'(frame_height), MAX_H);

        // Coincident lck fall and llp rise at y=5, with one back-to-back llp on the way
        for (int l = 0; l < 5; l++) begin
            lcks(int'($urandom_range(1, 8)));
            llp_pulse(1'b0);
            if (l == 2) llp_pulse(1'b0);
        end
        lcks(3);
        lck_llp_same(4'($urandom), sx, sy, seen);
        check("same_clk_seen", seen, 1);
        check("same_clk_x", sx, 0);
        check("same_clk_y", sy, 6);
        lcks(4);
        settle("same_clk");

        // Asynchronous reset mid-line
        lcks(3);
        repeat (LAT + 4) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_wr", int'({wr_en, wr_x, wr_y, wr_data}), 0);
        check("async_rst_geom", int'({frame_start, frame_width, frame_height, geom_valid, overrun}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        lcks(4);
        llp_pulse(1'b0);
        lcks(2);
        settle("post_rst_hunt");

        // Re-acquire with two identical small frames, then stall llp
        for (int f = 0; f < 2; f++) begin
            llp_pulse(1'b1);
            for (int l = 0; l < 2; l++) begin
                if (l != 0) llp_pulse(1'b0);
                lcks(8);
            end
        end
        llp_pulse(1'b1);
        settle("relock");
        check("relock_geom_valid", int'(geom_valid), 1);
        lcks(5);
        repeat ((1 << LOCK_LOG2) + 50) @(negedge clk);
        model_lost_lock();
        settle("lost_lock");
        check("lost_lock_geom_valid", int'(geom_valid), 0);
        check("lost_lock_width_held", int'(frame_width), 32);
        lcks(6);
        llp_pulse(1'b1);
        lcks(4);
        settle("final");

        check("wr_queue_drained", wr_q.size(), 0);
        check("fs_queue_drained", fs_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
